// File: rtl/led_bin2seg_conv.sv
// led_bin2seg_conv: binary to 7-segment pattern converter feeding led_display_ctrl.
// Accepts a value over valid/ready. Hex digits are taken directly from the
// captured value. Decimal digits come from a sequential double-dabble that
// takes DATA_W cycles. The NUM x 8-bit segment array updates in a single cycle
// after the conversion finishes, so a partial result is never shown.
// Segment codes are active-high: bit0 = a ... bit6 = g, bit7 = dp.
// Optional macro LEAD_ZERO_BLANK_EN blanks the leading zero digits. Digit 0 is
// always shown, and blanking is not applied to overflow.
module led_bin2seg_conv #(
  parameter int NUM    = 8,
  parameter int DATA_W = 27
) (
  input  logic                external_clk,
  input  logic                external_rstn,
  input  logic [DATA_W-1:0]   bin_data,
  input  logic                dec_mode,
  input  logic [NUM-1:0]      dp_mask,
  input  logic                bin_valid,
  output logic                bin_ready,
  output logic [NUM*8-1:0]    led_seg_out,
  output logic                busy,
  output logic                upd_done,
  output logic                ovf
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    ENCODE = 2'd2
  } state_t;

  // 10**n, used to build the decimal overflow limit
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] DEC_LIMIT = pow10(NUM);

  // Hex digit to active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, data} left
  function automatic logic [4*NUM+DATA_W-1:0] dabble_step(
    input logic [4*NUM-1:0]  bcd,
    input logic [DATA_W-1:0] data
  );
    logic [4*NUM-1:0] adj;
    for (int k = 0; k < NUM; k++) begin
      adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? (bcd[4*k +: 4] + 4'd3) : bcd[4*k +: 4];
    end
    return {adj, data} << 1;
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [DATA_W-1:0]   data_r;
  logic [4*NUM-1:0]    bcd_r;
  logic                dec_r;
  logic [NUM-1:0]      dp_r;
  logic                ovf_pend_r;
  logic [CNT_W-1:0]    cnt_r;

  logic                xfer_s;
  logic [63:0]         bin_ext_s;
  logic                in_ovf_s;
  logic [4*NUM-1:0]    hex_src_s;
  logic [4*NUM-1:0]    digit_src_s;
  logic [NUM*8-1:0]    enc_s;

  assign bin_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign xfer_s    = bin_valid && bin_ready;
  assign bin_ext_s = 64'(bin_data);

  // Overflow check on the incoming value. Decimal compares against 10**NUM;
  // hex tests for any bit at or above 4*NUM.
  always_comb begin
    in_ovf_s = 1'b0;
    if (dec_mode) begin
      in_ovf_s = (bin_ext_s >= DEC_LIMIT);
    end else begin
      in_ovf_s = ((bin_ext_s >> (4*NUM)) != 64'd0);
    end
  end

  // Hex digits come straight from the captured value, zero-padded when narrower
  if (DATA_W >= 4*NUM) begin : g_hex_trunc
    assign hex_src_s = data_r[4*NUM-1:0];
  end else begin : g_hex_pad
    assign hex_src_s = {{(4*NUM-DATA_W){1'b0}}, data_r};
  end

  // State register
  always_ff @(posedge external_clk or negedge external_rstn) begin
    if (!external_rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          if (in_ovf_s) begin
            state_nx_s = ENCODE;
          end else if (dec_mode) begin
            state_nx_s = CONV;
          end else begin
            state_nx_s = ENCODE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONV: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ENCODE;
        end else begin
          state_nx_s = CONV;
        end
      end
      ENCODE:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Capture on transfer, then run one double-dabble step per CONV cycle
  always_ff @(posedge external_clk or negedge external_rstn) begin
    if (!external_rstn) begin
      data_r     <= '0;
      bcd_r      <= '0;
      dec_r      <= 1'b0;
      dp_r       <= '0;
      ovf_pend_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            data_r     <= bin_data;
            dec_r      <= dec_mode;
            dp_r       <= dp_mask;
            ovf_pend_r <= in_ovf_s;
            bcd_r      <= '0;
            cnt_r      <= '0;
          end
        end
        CONV: begin
          {bcd_r, data_r} <= dabble_step(bcd_r, data_r);
          cnt_r           <= cnt_r + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Segment encoding of all digits, with dp, overflow dashes and optional blanking
  always_comb begin
    enc_s       = '0;
    digit_src_s = dec_r ? bcd_r : hex_src_s;
`ifdef LEAD_ZERO_BLANK_EN
    begin : blk_blank
      logic seen;
      seen = 1'b0;
      for (int i = NUM-1; i >= 0; i--) begin
        if (digit_src_s[4*i +: 4] != 4'd0) begin
          seen = 1'b1;
        end else begin
          seen = seen;
        end
        if (ovf_pend_r) begin
          enc_s[8*i +: 8] = 8'h40;
        end else if (!seen && (i != 0)) begin
          enc_s[8*i +: 8] = {dp_r[i], 7'h00};
        end else begin
          enc_s[8*i +: 8] = {dp_r[i], hex_seg(digit_src_s[4*i +: 4])};
        end
      end
    end
`else
    for (int i = 0; i < NUM; i++) begin
      if (ovf_pend_r) begin
        enc_s[8*i +: 8] = 8'h40;
      end else begin
        enc_s[8*i +: 8] = {dp_r[i], hex_seg(digit_src_s[4*i +: 4])};
      end
    end
`endif
  end

  // Output array, ovf flag and update pulse change only in the ENCODE cycle
  always_ff @(posedge external_clk or negedge external_rstn) begin
    if (!external_rstn) begin
      led_seg_out <= '0;
      upd_done    <= 1'b0;
      ovf         <= 1'b0;
    end else if (state_r == ENCODE) begin
      led_seg_out <= enc_s;
      upd_done    <= 1'b1;
      ovf         <= ovf_pend_r;
    end else begin
      upd_done    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_bin2seg_conv.sv
// Self-checking bench for led_bin2seg_conv (NUM = 8, DATA_W = 27).
// Expected patterns come from an arithmetic digit model (divide/modulo by the base).
module tb_led_bin2seg_conv;

  logic        external_clk = 1'b0;
  logic        external_rstn;
  logic [26:0] bin_data;
  logic        dec_mode;
  logic [7:0]  dp_mask;
  logic        bin_valid;
  logic        bin_ready;
  logic [63:0] led_seg_out;
  logic        busy;
  logic        upd_done;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  led_bin2seg_conv #(.NUM(8), .DATA_W(27)) dut (
    .external_clk (external_clk),
    .external_rstn(external_rstn),
    .bin_data     (bin_data),
    .dec_mode     (dec_mode),
    .dp_mask      (dp_mask),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .led_seg_out  (led_seg_out),
    .busy         (busy),
    .upd_done     (upd_done),
    .ovf          (ovf)
  );

  always #5 external_clk = ~external_clk;

  function automatic bit model_ovf(input logic [26:0] v, input logic dec);
    longint unsigned val;
    val = 64'(v);
    if (dec) return (val >= 64'd100000000);
    return (val >= 64'h1_0000_0000);
  endfunction

  function automatic logic [63:0] model_seg(input logic [26:0] v, input logic dec, input logic [7:0] dp);
    longint unsigned val, base, p;
    int dig [8];
    int top;
    logic [63:0] r;
    val  = 64'(v);
    base = dec ? 64'd10 : 64'd16;
    if (model_ovf(v, dec)) return {8{8'h40}};
    p   = 64'd1;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      dig[i] = int'((val / p) % base);
      if (dig[i] != 0) top = i;
      p = p * base;
    end
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = seg_tbl[dig[i]] | {dp[i], 7'h00};
`ifdef LEAD_ZERO_BLANK_EN
      if (i > top) r[8*i +: 8] = {dp[i], 7'h00};
`endif
    end
    return r;
  endfunction

  // Drive one transfer; returns right after the transfer edge (+1)
  task automatic start_xfer(input logic [26:0] v, input logic dec, input logic [7:0] dp);
    @(negedge external_clk);
    bin_data  = v;
    dec_mode  = dec;
    dp_mask   = dp;
    bin_valid = 1'b1;
    @(posedge external_clk);
    #1;
    bin_valid = 1'b0;
  endtask

  // Wait for upd_done (bounded); count edges and busy cycles
  task automatic wait_upd(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (upd_done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge external_clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    external_rstn = 1'b0;
    bin_valid = 1'b0; bin_data = '0; dec_mode = 1'b0; dp_mask = '0;
    #12;
    n_checks++;
    if (led_seg_out !== 64'd0 || busy !== 1'b0 || ovf !== 1'b0 || upd_done !== 1'b0 || bin_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got seg=%h busy=%b ovf=%b upd=%b rdy=%b, want 0 0 0 0 1",
               led_seg_out, busy, ovf, upd_done, bin_ready);
    end
    @(negedge external_clk);
    external_rstn = 1'b1;
    repeat (5) @(posedge external_clk);
    #1;
    n_checks++;
    if (led_seg_out !== 64'd0 || busy !== 1'b0 || ovf !== 1'b0 || upd_done !== 1'b0 || bin_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: got seg=%h busy=%b ovf=%b upd=%b rdy=%b, want 0 0 0 0 1",
               led_seg_out, busy, ovf, upd_done, bin_ready);
    end
  endtask

  task automatic test_hex;
    int lat, bc;
    logic [63:0] exp_seg;
    exp_seg = model_seg(27'h012ABCF, 1'b0, 8'h00);
    start_xfer(27'h012ABCF, 1'b0, 8'h00);
    wait_upd(lat, bc);
    n_checks++;
    if (led_seg_out !== exp_seg || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL hex_value: got seg=%h ovf=%b, want seg=%h ovf=0", led_seg_out, ovf, exp_seg);
    end
    n_checks++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL hex_latency: got %0d edges, want 1", lat);
    end
  endtask

  task automatic test_decimal;
    int lat, bc;
    start_xfer(27'd12345678, 1'b1, 8'h00);
    n_checks++;
    if (led_seg_out !== 64'h3F3F065B777C3971 && led_seg_out !== 64'h0000065B777C3971) begin
      n_fail++;
      $display("FAIL dec_hold_prev: got seg=%h, want previous hex result", led_seg_out);
    end
    wait_upd(lat, bc);
    n_checks++;
    if (led_seg_out !== 64'h065B4F666D7D077F) begin
      n_fail++;
      $display("FAIL dec_value: got seg=%h, want 065b4f666d7d077f", led_seg_out);
    end
    n_checks++;
    if (lat != 28 || bc != 28) begin
      n_fail++;
      $display("FAIL dec_latency: got lat=%0d busy=%0d, want 28 28", lat, bc);
    end
  endtask

  task automatic test_overflow;
    int lat, bc;
    start_xfer(27'd100000000, 1'b1, 8'hFF);
    wait_upd(lat, bc);
    n_checks++;
    if (led_seg_out !== {8{8'h40}} || ovf !== 1'b1 || lat != 1) begin
      n_fail++;
      $display("FAIL ovf_dec: got seg=%h ovf=%b lat=%0d, want all 40 ovf=1 lat=1", led_seg_out, ovf, lat);
    end
    start_xfer(27'd7, 1'b1, 8'h00);
    wait_upd(lat, bc);
    n_checks++;
    if (ovf !== 1'b0 || led_seg_out[7:0] !== 8'h07 || led_seg_out !== model_seg(27'd7, 1'b1, 8'h00)) begin
      n_fail++;
      $display("FAIL ovf_clear: got seg=%h ovf=%b, want seg=%h ovf=0", led_seg_out, ovf, model_seg(27'd7, 1'b1, 8'h00));
    end
  endtask

  task automatic test_dp;
    int lat, bc;
    logic [63:0] exp_seg;
`ifdef LEAD_ZERO_BLANK_EN
    exp_seg = 64'h000000000080006D;
`else
    exp_seg = 64'h3F3F3F3F3FBF3F6D;
`endif
    start_xfer(27'd5, 1'b1, 8'h04);
    wait_upd(lat, bc);
    n_checks++;
    if (led_seg_out !== exp_seg) begin
      n_fail++;
      $display("FAIL dp_digits: got seg=%h, want %h", led_seg_out, exp_seg);
    end
  endtask

  task automatic test_ignore_valid;
    int lat;
    int extra;
    start_xfer(27'd99999999, 1'b1, 8'h00);
    lat = 0;
    while (upd_done !== 1'b1 && lat < 100) begin
      if (lat == 9) begin
        @(negedge external_clk);
        bin_data = 27'd42; dec_mode = 1'b1; bin_valid = 1'b1;
        @(posedge external_clk);
        #1;
        bin_valid = 1'b0;
      end else begin
        @(posedge external_clk);
        #1;
      end
      lat++;
    end
    n_checks++;
    if (led_seg_out !== {8{8'h6F}} || lat != 28) begin
      n_fail++;
      $display("FAIL ignore_valid: got seg=%h lat=%0d, want all 6f lat=28", led_seg_out, lat);
    end
    extra = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge external_clk);
      #1;
      if (upd_done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0 || led_seg_out !== {8{8'h6F}}) begin
      n_fail++;
      $display("FAIL no_queue: got %0d busy/upd cycles seg=%h, want 0 and all 6f", extra, led_seg_out);
    end
  endtask

  task automatic test_reset_mid;
    int upd_seen;
    start_xfer(27'd99999999, 1'b1, 8'h00);
    repeat (5) @(posedge external_clk);
    #2;
    external_rstn = 1'b0;
    #1;
    n_checks++;
    if (led_seg_out !== 64'd0 || busy !== 1'b0 || upd_done !== 1'b0 || ovf !== 1'b0 || bin_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got seg=%h busy=%b upd=%b ovf=%b rdy=%b, want 0 0 0 0 1",
               led_seg_out, busy, upd_done, ovf, bin_ready);
    end
    @(negedge external_clk);
    external_rstn = 1'b1;
    upd_seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge external_clk);
      #1;
      if (upd_done === 1'b1 || led_seg_out !== 64'd0) upd_seen++;
    end
    n_checks++;
    if (upd_seen != 0) begin
      n_fail++;
      $display("FAIL reset_discard: got %0d cycles with update, want 0", upd_seen);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    start_xfer(27'h0000ABC, 1'b0, 8'h01);
    wait_upd(lat, bc);
    n_checks++;
    if (bin_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready: got rdy=%b busy=%b, want 1 0", bin_ready, busy);
    end
    start_xfer(27'd4321, 1'b1, 8'h00);
    wait_upd(lat, bc);
    n_checks++;
    if (led_seg_out !== model_seg(27'd4321, 1'b1, 8'h00) || lat != 28) begin
      n_fail++;
      $display("FAIL b2b_dec: got seg=%h lat=%0d, want seg=%h lat=28", led_seg_out, lat, model_seg(27'd4321, 1'b1, 8'h00));
    end
    start_xfer(27'h7FFFFFF, 1'b0, 8'h80);
    wait_upd(lat, bc);
    n_checks++;
    if (led_seg_out !== model_seg(27'h7FFFFFF, 1'b0, 8'h80) || lat != 1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hex: got seg=%h lat=%0d ovf=%b, want seg=%h lat=1 ovf=0",
               led_seg_out, lat, ovf, model_seg(27'h7FFFFFF, 1'b0, 8'h80));
    end
  endtask

  task automatic test_random;
    int lat, bc, exp_lat;
    logic [26:0] v;
    logic        d;
    logic [7:0]  dp;
    logic [63:0] exp_seg;
    bit          exp_ovf;
    for (int n = 0; n < 40; n++) begin
      d  = 1'($urandom_range(0, 1));
      dp = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       v = 27'($urandom_range(0, 99));
        1:       v = 27'($urandom_range(99999990, 100000009));
        2:       v = 27'($urandom_range(0, 99999999));
        default: v = 27'($urandom);
      endcase
      exp_seg = model_seg(v, d, dp);
      exp_ovf = model_ovf(v, d);
      exp_lat = (d && !exp_ovf) ? 28 : 1;
      start_xfer(v, d, dp);
      wait_upd(lat, bc);
      n_checks++;
      if (led_seg_out !== exp_seg || ovf !== exp_ovf || lat != exp_lat) begin
        n_fail++;
        $display("FAIL random_%0d: v=%0d dec=%b dp=%h got seg=%h ovf=%b lat=%0d, want seg=%h ovf=%b lat=%0d",
                 n, v, d, dp, led_seg_out, ovf, lat, exp_seg, exp_ovf, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_hex;
    test_decimal;
    test_overflow;
    test_dp;
    test_ignore_valid;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
